// File: rtl/beam_cfg_serializer_if.sv
// Sequencer-side bus of the beam-configuration serializer.
// Strobe semantics: cfg_valid is a one-cycle strobe with no ready; the serializer always accepts the word, and busy is status only.
interface beam_cfg_serializer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] cfg_word;
    logic             cfg_valid;
    logic             busy;
    logic             done;
    logic             overrun;

    modport master (
        output cfg_word,
        output cfg_valid,
        input  busy,
        input  done,
        input  overrun
    );

    modport slave (
        input  cfg_word,
        input  cfg_valid,
        output busy,
        output done,
        output overrun
    );
endinterface

// File: rtl/beam_cfg_serializer.sv
// Shifts a parallel config word MSB-first onto the sclk/sdata/sle link of the beamformer,
// with one pending word so the sequencer can queue the next configuration mid-frame.
module beam_cfg_serializer #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    beam_cfg_serializer_if.slave  cfg,
    output logic                  sclk,
    output logic                  sdata,
    output logic                  sle,
    output logic [1:0]            state_o,
    output logic                  pend_valid_o
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] pend_q;
    logic             pend_valid_q;
    logic [CNT_W-1:0] bitcnt_q;
    logic [DIV_W-1:0] div_q;
    logic             busy_q;
    logic             done_q;
    logic             overrun_q;
    logic             sclk_q;
    logic             sdata_q;
    logic             sle_q;

    logic             tick;
    logic             capture;
    logic             launch;
    logic [WIDTH-1:0] launch_d;

    assign tick = (div_q == DIV_W'(CLK_DIV - 1));

    // A strobe on the final LATCH cycle launches directly instead of going to the pending slot.
    assign capture  = cfg.cfg_valid && (state_q != IDLE) && !((state_q == LATCH) && tick);
    assign launch   = ((state_q == IDLE) && cfg.cfg_valid) ||
                      ((state_q == LATCH) && tick && (cfg.cfg_valid || pend_valid_q));
    assign launch_d = ((state_q == LATCH) && !cfg.cfg_valid && pend_valid_q) ? pend_q : cfg.cfg_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            bitcnt_q     <= '0;
            div_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            sclk_q       <= 1'b0;
            sdata_q      <= 1'b0;
            sle_q        <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            overrun_q <= 1'b0;

            if (capture) begin
                pend_q       <= cfg.cfg_word;
                pend_valid_q <= 1'b1;
                if (pend_valid_q) overrun_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    div_q <= '0;
                end
                SETUP: begin
                    if (tick) begin
                        div_q   <= '0;
                        sclk_q  <= 1'b1;
                        state_q <= HIGH;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                HIGH: begin
                    if (tick) begin
                        div_q  <= '0;
                        sclk_q <= 1'b0;
                        if (bitcnt_q != '0) begin
                            shreg_q  <= shreg_q << 1;
                            sdata_q  <= shreg_q[WIDTH-2];
                            bitcnt_q <= bitcnt_q - CNT_W'(1);
                            state_q  <= SETUP;
                        end else begin
                            sdata_q <= 1'b0;
                            sle_q   <= 1'b1;
                            state_q <= LATCH;
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                LATCH: begin
                    if (tick) begin
                        div_q        <= '0;
                        sle_q        <= 1'b0;
                        done_q       <= 1'b1;
                        pend_valid_q <= 1'b0;
                        if (cfg.cfg_valid && pend_valid_q) overrun_q <= 1'b1;
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Launching a frame overrides the IDLE fall-through above, so back-to-back frames keep busy high.
            if (launch) begin
                state_q  <= SETUP;
                shreg_q  <= launch_d;
                bitcnt_q <= CNT_W'(WIDTH - 1);
                sdata_q  <= launch_d[WIDTH-1];
                busy_q   <= 1'b1;
                div_q    <= '0;
            end
        end
    end

    assign cfg.busy     = busy_q;
    assign cfg.done     = done_q;
    assign cfg.overrun  = overrun_q;
    assign sclk         = sclk_q;
    assign sdata        = sdata_q;
    assign sle          = sle_q;
    assign state_o      = state_q;
    assign pend_valid_o = pend_valid_q;
endmodule

// File: tb/tb_beam_cfg_serializer.sv
// Directed bench for beam_cfg_serializer: one DUT at CLK_DIV=4 and one at CLK_DIV=1, with a
// serial-link monitor per DUT that decodes frames and compares them against expected-word queues.
module tb_beam_cfg_serializer;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    beam_cfg_serializer_if #(.WIDTH(W)) bus0 ();
    beam_cfg_serializer_if #(.WIDTH(W)) bus1 ();

    logic       sclk0, sdata0, sle0, pv0;
    logic       sclk1, sdata1, sle1, pv1;
    logic [1:0] st0, st1;

    beam_cfg_serializer #(.WIDTH(W), .CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .cfg(bus0), .sclk(sclk0), .sdata(sdata0), .sle(sle0),
        .state_o(st0), .pend_valid_o(pv0)
    );

    beam_cfg_serializer #(.WIDTH(W), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .cfg(bus1), .sclk(sclk1), .sdata(sdata1), .sle(sle1),
        .state_o(st1), .pend_valid_o(pv1)
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp0_q[$];
    logic [W-1:0] exp1_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor, CLK_DIV=4 ----------------
    int           m0_bits = 0, m0_since = 0, rise0_cnt = 0, sle0_cyc = 0, done0_cnt = 0, ovr0_cnt = 0;
    logic         m0_have = 1'b0, m0_prev_sclk = 1'b0, m0_prev_sle = 1'b0;
    logic [W-1:0] m0_shv = '0;
    logic [W-1:0] m0_exp;

    always @(negedge clk) begin
        if (rst) begin
            m0_bits = 0; m0_since = 0; m0_have = 1'b0; m0_shv = '0;
            m0_prev_sclk = 1'b0; m0_prev_sle = 1'b0;
        end else begin
            m0_since++;
            if (sclk0 != m0_prev_sclk) begin
                if (m0_have) check("sclk0_half_period", 32'(m0_since), 32'd4);
                m0_have = 1'b1; m0_since = 0;
                if (sclk0) begin
                    m0_shv = {m0_shv[W-2:0], sdata0};
                    m0_bits++; rise0_cnt++;
                end
            end else if (sclk0) begin
                check("sdata0_stable_high", 32'(sdata0), 32'(m0_shv[0]));
            end
            if (sle0) sle0_cyc++;
            if (sle0 && !m0_prev_sle) begin
                m0_have = 1'b0;
                check("frame0_bits", 32'(m0_bits), 32'(W));
                checks++;
                assert (exp0_q.size() != 0) else begin
                    failures++;
                    $error("FAIL frame0_unexpected observed=%0h expected=none", m0_shv);
                end
                if (exp0_q.size() != 0) begin
                    m0_exp = exp0_q.pop_front();
                    check("frame0_word", 32'(m0_shv), 32'(m0_exp));
                end
                m0_bits = 0;
            end
            if (bus0.done) done0_cnt++;
            if (bus0.overrun) ovr0_cnt++;
            m0_prev_sclk = sclk0; m0_prev_sle = sle0;
        end
    end

    // ---------------- monitor, CLK_DIV=1 ----------------
    int           m1_bits = 0, m1_since = 0, rise1_cnt = 0;
    logic         m1_have = 1'b0, m1_prev_sclk = 1'b0, m1_prev_sle = 1'b0;
    logic [W-1:0] m1_shv = '0;
    logic [W-1:0] m1_exp;

    always @(negedge clk) begin
        if (rst) begin
            m1_bits = 0; m1_since = 0; m1_have = 1'b0; m1_shv = '0;
            m1_prev_sclk = 1'b0; m1_prev_sle = 1'b0;
        end else begin
            m1_since++;
            if (sclk1 != m1_prev_sclk) begin
                if (m1_have) check("sclk1_half_period", 32'(m1_since), 32'd1);
                m1_have = 1'b1; m1_since = 0;
                if (sclk1) begin
                    m1_shv = {m1_shv[W-2:0], sdata1};
                    m1_bits++; rise1_cnt++;
                end
            end
            if (sle1 && !m1_prev_sle) begin
                m1_have = 1'b0;
                check("frame1_bits", 32'(m1_bits), 32'(W));
                checks++;
                assert (exp1_q.size() != 0) else begin
                    failures++;
                    $error("FAIL frame1_unexpected observed=%0h expected=none", m1_shv);
                end
                if (exp1_q.size() != 0) begin
                    m1_exp = exp1_q.pop_front();
                    check("frame1_word", 32'(m1_shv), 32'(m1_exp));
                end
                m1_bits = 0;
            end
            m1_prev_sclk = sclk1; m1_prev_sle = sle1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic strobe(input int which, input logic [W-1:0] w);
        @(posedge clk); #1;
        if (which == 0) begin bus0.cfg_word = w; bus0.cfg_valid = 1'b1; end
        else            begin bus1.cfg_word = w; bus1.cfg_valid = 1'b1; end
        @(posedge clk); #1;
        bus0.cfg_valid = 1'b0;
        bus1.cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input int which, input string tag, input int limit, output int cyc);
        logic seen;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(posedge clk); #1;
            cyc++;
            seen = (which == 0) ? bus0.done : bus1.done;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    int cyc, dn, gaps, span, base_ovr, base_rise, base_sle, base_done;

    initial begin
        bus0.cfg_word = '0; bus0.cfg_valid = 1'b0;
        bus1.cfg_word = '0; bus1.cfg_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus0.busy), 32'd0);
        check("rst_done", 32'(bus0.done), 32'd0);
        check("rst_overrun", 32'(bus0.overrun), 32'd0);
        check("rst_sclk", 32'(sclk0), 32'd0);
        check("rst_sdata", 32'(sdata0), 32'd0);
        check("rst_sle", 32'(sle0), 32'd0);
        check("rst_state", 32'(st0), 32'd0);
        check("rst_pend", 32'(pv0), 32'd0);
        rst = 1'b0;

        // Single frame A53C
        base_rise = rise0_cnt; base_sle = sle0_cyc;
        exp0_q.push_back(16'hA53C);
        strobe(0, 16'hA53C);
        check("t1_busy_rise", 32'(bus0.busy), 32'd1);
        check("t1_sdata_msb", 32'(sdata0), 32'd1);
        check("t1_state_setup", 32'(st0), 32'd1);
        wait_done(0, "t1_done_seen", 200, cyc);
        check("t1_frame_len", 32'(cyc), 32'd132);
        check("t1_busy_fall", 32'(bus0.busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("t1_sclk_rises", 32'(rise0_cnt - base_rise), 32'd16);
        check("t1_sle_cycles", 32'(sle0_cyc - base_sle), 32'd4);
        check("t1_queue_empty", 32'(exp0_q.size()), 32'd0);

        // Back-to-back 0001 then FFFF
        base_ovr = ovr0_cnt;
        exp0_q.push_back(16'h0001);
        exp0_q.push_back(16'hFFFF);
        strobe(0, 16'h0001);
        repeat (18) @(posedge clk);
        strobe(0, 16'hFFFF);
        check("t2_pending_set", 32'(pv0), 32'd1);
        dn = 0; gaps = 0; span = 0;
        for (int i = 0; i < 400 && dn < 2; i++) begin
            @(posedge clk); #1;
            if (dn == 1) span++;
            if (bus0.done) dn++;
            else if (!bus0.busy) gaps++;
        end
        check("t2_dones", 32'(dn), 32'd2);
        check("t2_busy_gap", 32'(gaps), 32'd0);
        check("t2_second_len", 32'(span), 32'd132);
        check("t2_no_overrun", 32'(ovr0_cnt - base_ovr), 32'd0);
        check("t2_queue_empty", 32'(exp0_q.size()), 32'd0);

        // Overrun: 2222 is overwritten by 3333
        base_ovr = ovr0_cnt;
        exp0_q.push_back(16'h1111);
        exp0_q.push_back(16'h3333);
        strobe(0, 16'h1111);
        repeat (10) @(posedge clk);
        strobe(0, 16'h2222);
        check("t3_ovr_second", 32'(bus0.overrun), 32'd0);
        repeat (10) @(posedge clk);
        strobe(0, 16'h3333);
        check("t3_ovr_third", 32'(bus0.overrun), 32'd1);
        wait_done(0, "t3_done1_seen", 300, cyc);
        wait_done(0, "t3_done2_seen", 300, cyc);
        check("t3_ovr_count", 32'(ovr0_cnt - base_ovr), 32'd1);
        check("t3_queue_empty", 32'(exp0_q.size()), 32'd0);

        // Strobe on the LATCH tick with 00FF pending
        base_ovr = ovr0_cnt;
        exp0_q.push_back(16'h1234);
        exp0_q.push_back(16'hF00F);
        strobe(0, 16'h1234);
        repeat (10) @(posedge clk);
        strobe(0, 16'h00FF);
        for (int i = 0; i < 300 && !sle0; i++) begin
            @(posedge clk); #1;
        end
        check("t4_sle_seen", 32'(sle0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        bus0.cfg_word = 16'hF00F; bus0.cfg_valid = 1'b1;
        @(posedge clk); #1;
        bus0.cfg_valid = 1'b0;
        check("t4_done", 32'(bus0.done), 32'd1);
        check("t4_overrun", 32'(bus0.overrun), 32'd1);
        check("t4_pend_cleared", 32'(pv0), 32'd0);
        check("t4_busy_held", 32'(bus0.busy), 32'd1);
        check("t4_state_setup", 32'(st0), 32'd1);
        check("t4_sdata_msb", 32'(sdata0), 32'd1);
        wait_done(0, "t4_done_seen", 300, cyc);
        check("t4_ovr_count", 32'(ovr0_cnt - base_ovr), 32'd1);
        check("t4_queue_empty", 32'(exp0_q.size()), 32'd0);

        // Reset mid-frame after 7 bits of FFFF
        base_rise = rise0_cnt;
        strobe(0, 16'hFFFF);
        for (int i = 0; i < 200 && (rise0_cnt - base_rise) < 7; i++) begin
            @(posedge clk); #1;
        end
        check("t5_seven_bits", 32'(rise0_cnt - base_rise), 32'd7);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_busy", 32'(bus0.busy), 32'd0);
        check("t5_sclk", 32'(sclk0), 32'd0);
        check("t5_sdata", 32'(sdata0), 32'd0);
        check("t5_sle", 32'(sle0), 32'd0);
        check("t5_done", 32'(bus0.done), 32'd0);
        check("t5_overrun", 32'(bus0.overrun), 32'd0);
        check("t5_state", 32'(st0), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        base_done = done0_cnt;
        repeat (200) @(posedge clk);
        #1;
        check("t5_no_done", 32'(done0_cnt - base_done), 32'd0);
        check("t5_idle_busy", 32'(bus0.busy), 32'd0);
        check("t5_idle_state", 32'(st0), 32'd0);
        exp0_q.push_back(16'h8001);
        strobe(0, 16'h8001);
        wait_done(0, "t5_done_seen", 200, cyc);
        check("t5_frame_len", 32'(cyc), 32'd132);
        check("t5_queue_empty", 32'(exp0_q.size()), 32'd0);

        // CLK_DIV=1 instance sends 5555
        base_rise = rise1_cnt;
        exp1_q.push_back(16'h5555);
        strobe(1, 16'h5555);
        check("t6_busy_rise", 32'(bus1.busy), 32'd1);
        check("t6_sdata_msb", 32'(sdata1), 32'd0);
        wait_done(1, "t6_done_seen", 100, cyc);
        check("t6_frame_len", 32'(cyc), 32'd33);
        check("t6_busy_fall", 32'(bus1.busy), 32'd0);
        check("t6_sclk_rises", 32'(rise1_cnt - base_rise), 32'd16);
        check("t6_queue_empty", 32'(exp1_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
